// File: rtl/fsub_pipe.sv
// fsub_pipe -- three-stage pipelined IEEE-754 single-precision subtractor, d = s - t.
//
// Stages:  1 align  (sign flip, flush, swap, exponent diff, right shift + sticky, specials)
//          2 add    (28-bit magnitude add/sub with sticky as LSB, leading-zero count)
//          3 round  (normalise, round-to-nearest-even, overflow/flush, output register)
// Denormal inputs are read as signed zero; denormal results become +0.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready is the pipeline advance condition)
//   s, t                 minuend, subtrahend
//   op_add               only with FSUB_PIPE_ADD_OP_EN defined: 1 computes s + t
//   out_valid/out_ready  result handshake
//   d, overflow          registered result; overflow marks finite operands that rounded to inf
//
// Build option: define FSUB_PIPE_ADD_OP_EN to add the op_add input.

module fsub_pipe #(
  parameter logic [31:0] QNAN = 32'h7fc00000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  input  logic [31:0] t,
`ifdef FSUB_PIPE_ADD_OP_EN
  input  logic        op_add,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        overflow
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic        spec;      // special-case result replaces the arithmetic path
    logic [31:0] spec_val;
    logic        sign;      // sign of the larger-magnitude operand
    logic [7:0]  exp;
    logic        eff_sub;
    logic [26:0] mg;        // carry, hidden, 23 frac, guard, round
    logic [26:0] ml;        // smaller operand, already aligned
    logic        sticky;
  } s1_t;

  typedef struct packed {
    logic        spec;
    logic [31:0] spec_val;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;       // carry, hidden, 23 frac, G, R, S
    logic [4:0]  lzc;
  } s2_t;

  // ---------------------------------------------------------------- control
  logic [STAGES:1] vld_pipe;
  logic            adv, in_fire;

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign in_fire   = in_valid && adv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
  end

  // ---------------------------------------------------------------- stage 1
  logic        add_op;
`ifdef FSUB_PIPE_ADD_OP_EN
  assign add_op = op_add;
`else
  assign add_op = 1'b0;
`endif

  logic        a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [7:0]  a_exp, b_exp, g_exp, l_exp, e_diff;
  logic [22:0] a_frac, b_frac, g_frac, l_frac;
  logic        g_sign, l_sign, g_zero, l_zero;
  logic [4:0]  sh;
  logic [52:0] l_wide;
  s1_t         s1_n, s1_q;

  assign a_sign = s[31];
  assign b_sign = t[31] ^ ~add_op;   // subtraction becomes addition of -t
  assign a_exp  = s[30:23];
  assign b_exp  = t[30:23];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_frac = a_zero ? 23'd0 : s[22:0];
  assign b_frac = b_zero ? 23'd0 : t[22:0];
  assign a_inf  = (a_exp == 8'hff) && (s[22:0] == 23'd0);
  assign b_inf  = (b_exp == 8'hff) && (t[22:0] == 23'd0);
  assign a_nan  = (a_exp == 8'hff) && (s[22:0] != 23'd0);
  assign b_nan  = (b_exp == 8'hff) && (t[22:0] != 23'd0);

  assign swap   = {b_exp, b_frac} > {a_exp, a_frac};
  assign g_sign = swap ? b_sign : a_sign;
  assign l_sign = swap ? a_sign : b_sign;
  assign g_exp  = swap ? b_exp  : a_exp;
  assign l_exp  = swap ? a_exp  : b_exp;
  assign g_frac = swap ? b_frac : a_frac;
  assign l_frac = swap ? a_frac : b_frac;
  assign g_zero = swap ? b_zero : a_zero;
  assign l_zero = swap ? a_zero : b_zero;

  // A shift of 26 already pushes the hidden bit past the round bit, so
  // larger distances only ever contribute to sticky.
  assign e_diff = g_exp - l_exp;
  assign sh     = (e_diff > 8'd26) ? 5'd26 : e_diff[4:0];
  assign l_wide = {1'b0, ~l_zero, l_frac, 2'b00, 26'd0} >> sh;

  always_comb begin
    s1_n         = '0;
    s1_n.sign    = g_sign;
    s1_n.exp     = g_exp;
    s1_n.eff_sub = g_sign ^ l_sign;
    s1_n.mg      = {1'b0, ~g_zero, g_frac, 2'b00};
    s1_n.ml      = l_wide[52:26];
    s1_n.sticky  = |l_wide[25:0];
    s1_n.spec    = 1'b1;
    if (a_nan)                                s1_n.spec_val = s | 32'h0040_0000;
    else if (b_nan)                           s1_n.spec_val = t | 32'h0040_0000;
    else if (a_inf && b_inf && a_sign != b_sign) s1_n.spec_val = QNAN;
    else if (a_inf)                           s1_n.spec_val = s;
    else if (b_inf)                           s1_n.spec_val = {b_sign, t[30:0]};
    else if (a_zero && b_zero)                s1_n.spec_val = {a_sign & b_sign, 31'd0};
    else                                      s1_n.spec     = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    s1_q <= '0;
    else if (adv) s1_q <= s1_n;
  end

  // ---------------------------------------------------------------- stage 2
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] n;
    n = 5'd26;
    for (int i = 0; i < 26; i++)
      if (v[i]) n = 5'(25 - i);
    return n;
  endfunction

  logic [27:0] gw, lw, sum_n;
  s2_t         s2_n, s2_q;

  // Sticky sits in the LSB so a nonzero tail of l borrows from g. |g| >= |l|
  // keeps the difference non-negative.
  assign gw    = {s1_q.mg, 1'b0};
  assign lw    = {s1_q.ml, s1_q.sticky};
  assign sum_n = s1_q.eff_sub ? (gw - lw) : (gw + lw);

  always_comb begin
    s2_n          = '0;
    s2_n.spec     = s1_q.spec;
    s2_n.spec_val = s1_q.spec_val;
    s2_n.sign     = s1_q.sign;
    s2_n.exp      = s1_q.exp;
    s2_n.sum      = sum_n;
    s2_n.lzc      = lzc26(sum_n[26:1]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    s2_q <= '0;
    else if (adv) s2_q <= s2_n;
  end

  // ---------------------------------------------------------------- stage 3
  logic [26:0]       w;        // hidden, 23 frac, G, R, S after normalisation
  logic signed [9:0] e, e2;
  logic              inc;
  logic [24:0]       mr;
  logic [31:0]       d_n;
  logic              ov_n;
  logic              unused_bits;

  always_comb begin
    if (s2_q.sum[27]) begin
      // Carry out: the bit dropped by the right shift folds into sticky.
      w = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      e = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      w = s2_q.sum[26:0] << s2_q.lzc;
      e = $signed({2'b00, s2_q.exp}) - $signed({5'd0, s2_q.lzc});
    end
    inc  = w[2] & (w[1] | w[0] | w[3]);
    mr   = {1'b0, w[26:3]} + {24'd0, inc};
    e2   = mr[24] ? (e + 10'sd1) : e;   // rounding carried into a new binade
    d_n  = '0;
    ov_n = 1'b0;
    if (s2_q.spec)                                d_n = s2_q.spec_val;
    else if (s2_q.sum == 28'd0 || e <= 10'sd0)    d_n = '0;
    else if (e2 >= 10'sd255) begin
      d_n  = {s2_q.sign, 8'hff, 23'd0};
      ov_n = 1'b1;
    end else
      d_n = {s2_q.sign, e2[7:0], mr[24] ? 23'd0 : mr[22:0]};
  end

  // Hidden bit of the rounded mantissa is implicit in the encoding.
  assign unused_bits = mr[23];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d        <= '0;
      overflow <= 1'b0;
    end else if (adv && vld_pipe[STAGES-1]) begin
      d        <= d_n;
      overflow <= ov_n;
    end
  end

endmodule
